conv3x3_sequencer: RTL and testbench
====================================

// Module: conv3x3_sequencer
// PURPOSE
//  Sequencer and feeder for the 3x3 convolution datapath (`top`: state, ifmap_in, filter_in, psumOut).
//  - Accepts a raster-order pixel stream and keeps two line buffers plus a 3x3 window.
//  - Loads the filter with one state=1 cycle, then presents one 72-bit window per accepted pixel.
//  - Captures psumOut for valid windows only and reports frame completion.
// PARAMETERS
//  IMG_W       8   image width in pixels (>=3)
//  IMG_H       8   image height in pixels (>=3)
//  PE_LATENCY  1   cycles from conv_ifmap change to matching conv_psum (>=1)
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  start        in   1   begin frame; sampled in IDLE only
//  cfg_filter   in   72  filter weights, latched on accepted start
//  pix_valid    in   1   input pixel valid
//  pix_data     in   8   input pixel, unsigned
//  pix_ready    out  1   pixel accepted when pix_valid & pix_ready
//  conv_state   out  1   to datapath `state`: 1 = filter load, 0 = compute
//  conv_filter  out  72  to datapath `filter_in`
//  conv_ifmap   out  72  to datapath `ifmap_in`
//  conv_psum    in   16  from datapath `psumOut`
//  out_valid    out  1   one-cycle strobe, out_data valid
//  out_data     out  16  captured psum
//  out_last     out  1   high with the final out_valid of a frame
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle pulse at frame end
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; counters, window and valid pipeline cleared.
//   Line-buffer RAM is not cleared.
//  FSM:
//   - IDLE -> LOAD on start. Latch cfg_filter into conv_filter. Clear row/col.
//   - LOAD: one cycle, conv_state=1, conv_ifmap=0. -> STREAM.
//   - STREAM: pix_ready=1. Accept pixel at (row,col).
//     After accepting (IMG_H-1, IMG_W-1) -> DRAIN.
//   - DRAIN: pix_ready=0. Stays PE_LATENCY+1 cycles, then -> DONE.
//   - DONE: done=1 for one cycle -> IDLE.
//  start outside IDLE is ignored. conv_filter holds until the next accepted start.
//  Accept at column c:
//   - New column = {top=lb1[c], mid=lb0[c], bot=pix_data}.
//   - Update lb1[c]<=lb0[c], lb0[c]<=pix_data.
//   - Window columns shift left; new column enters at the right.
//   - col wraps IMG_W-1 -> 0 and increments row.
//  conv_ifmap packing: byte k=3*r+c (r=0 top row, c=0 left column) at bits [71-8k -: 8].
//   Registered: updated the cycle after the accept, held when no accept.
//  Window valid iff the accepted pixel has row>=2 and col>=2.
//   Wrap-around windows (col<2) are presented to the datapath but never reported.
//  Valid pipeline: wvalid goes through PE_LATENCY register stages.
//   out_valid=1, out_data=conv_psum exactly PE_LATENCY cycles after the matching conv_ifmap update.
//  Outputs per frame: exactly (IMG_W-2)*(IMG_H-2), in raster order of window centre.
//   out_last is set on the last one.
//  Stalls (pix_valid=0) insert gaps only; results and order are unchanged.
//   The final out_valid always occurs in DRAIN, before done.
//  No output backpressure: the consumer must accept each out_valid strobe.
//  rst mid-frame: abort immediately, outputs return to reset values, no done pulse.
//   The next frame is correct without clearing line buffers, because rows 0-1 are rewritten before use.
// TESTING
//  1. IMG_W=IMG_H=4, centre-only filter 72'h000000000100000000, pixels 0..15 continuous
//     -> out_data 5,6,9,10; out_last on 10; done 1 cycle after DRAIN.
//  2. Same image, filter 72'h010000000100000001
//     -> out_data 15,18,27,30, each one being (r-1,c-1)+(r,c)+(r+1,c+1).
//  3. Test 1 with pix_valid toggled pseudo-randomly
//     -> identical 4 results and order; pix_ready=0 in LOAD/DRAIN/DONE/IDLE.
//  4. start pulsed during STREAM
//     -> ignored; conv_filter unchanged; exactly 4 outputs and 1 done.
//  5. rst after 7 pixels accepted, then a new start and test 1 stimulus
//     -> no out_valid/done before the restart; results 5,6,9,10.
//  6. Check conv_state: 1 for exactly one cycle after start (conv_ifmap=0), otherwise 0.
//     Repeat with PE_LATENCY=3: each result is delayed 2 cycles more and the values are the same.

Source files
------------

// File: rtl/conv3x3_sequencer.sv
// conv3x3_sequencer
// Feeds a 3x3 convolution datapath from a raster-order pixel stream.
// It loads the filter once with conv_state=1. It then presents one 72-bit
// window per accepted pixel. It reports the datapath psum only for windows
// that lie fully inside the image, and it pulses done at the end of a frame.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, cfg_filter frame start (sampled in IDLE) and filter weights
//   pix_valid/ready   input pixel handshake, pix_data 8-bit unsigned
//   conv_state        1 = filter load, 0 = compute (to datapath `state`)
//   conv_filter       latched weights (to datapath `filter_in`)
//   conv_ifmap        current 3x3 window (to datapath `ifmap_in`)
//   conv_psum         datapath result (from `psumOut`)
//   out_valid/data    psum strobe and value, out_last on the frame's last one
//   busy, done        not-IDLE flag, one-cycle end-of-frame pulse
module conv3x3_sequencer #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int PE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [71:0] cfg_filter,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        conv_state,
  output logic [71:0] conv_filter,
  output logic [71:0] conv_ifmap,
  input  logic [15:0] conv_psum,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = $clog2(PE_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [71:0]     filter_q;
  logic [7:0]      win_q [3][3];            // [row][col], row 0 = top
  logic [7:0]      lb0 [IMG_W];             // previous row
  logic [7:0]      lb1 [IMG_W];             // row before that
  // Stage 0 is aligned with the conv_ifmap update; stage PE_LATENCY lines up
  // with the matching conv_psum.
  logic [PE_LATENCY:0] vld_q, last_q;

  logic accept, wvalid, wlast;

  assign accept = (state_q == S_STREAM) && pix_valid;
  assign wvalid = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign wlast  = wvalid && (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    drain_d    = drain_q;
    pix_ready  = 1'b0;
    conv_state = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_LOAD: begin
        conv_state = 1'b1;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        pix_ready = 1'b1;
        if (accept) begin
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (row_q == RW'(IMG_H - 1)) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(PE_LATENCY)) state_d = S_DONE;
        else                            drain_d = drain_q + DW'(1);
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    conv_ifmap = '0;
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned c = 0; c < 3; c++)
        conv_ifmap[71 - 8*(3*r + c) -: 8] = win_q[r][c];
  end

  assign conv_filter = filter_q;
  assign out_valid   = vld_q[PE_LATENCY];
  assign out_last    = last_q[PE_LATENCY];
  // The psum is passed through in the strobe cycle so it lines up exactly
  // PE_LATENCY cycles after the window was presented.
  assign out_data    = out_valid ? conv_psum : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      drain_q  <= '0;
      filter_q <= '0;
      vld_q    <= '0;
      last_q   <= '0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      vld_q   <= {vld_q[PE_LATENCY-1:0], wvalid};
      last_q  <= {last_q[PE_LATENCY-1:0], wlast};
      if (state_q == S_IDLE && start) begin
        filter_q <= cfg_filter;
        for (int unsigned r = 0; r < 3; r++)
          for (int unsigned c = 0; c < 3; c++)
            win_q[r][c] <= '0;
      end else if (accept) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1[col_q];
        win_q[1][2] <= lb0[col_q];
        win_q[2][2] <= pix_data;
      end
    end
  end

  // Line buffers are never cleared: rows 0-1 of each frame rewrite them
  // before any valid window reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_q] <= lb0[col_q];
      lb0[col_q] <= pix_data;
    end
  end

endmodule

// File: tb/tb_conv3x3_sequencer.sv
module tb_conv3x3_sequencer;
  localparam int W = 4;
  localparam int H = 4;
  localparam logic [71:0] F1 = 72'h000000000100000000;
  localparam logic [71:0] F2 = 72'h010000000100000001;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic [71:0] cfg_filter = '0;

  logic ready_a, cs_a, ov_a, ol_a, busy_a, done_a;
  logic ready_b, cs_b, ov_b, ol_b, busy_b, done_b;
  logic [71:0] cf_a, ci_a, cf_b, ci_b;
  logic [15:0] cp_a, od_a, cp_b, od_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int npop_a = 0, npop_b = 0, nd_a = 0, nd_b = 0, exp_done_a = -1, exp_done_b = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv3x3_sequencer #(.IMG_W(W), .IMG_H(H), .PE_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .cfg_filter(cfg_filter),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(ready_a),
    .conv_state(cs_a), .conv_filter(cf_a), .conv_ifmap(ci_a), .conv_psum(cp_a),
    .out_valid(ov_a), .out_data(od_a), .out_last(ol_a), .busy(busy_a), .done(done_a));

  conv3x3_sequencer #(.IMG_W(W), .IMG_H(H), .PE_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .cfg_filter(cfg_filter),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(ready_b),
    .conv_state(cs_b), .conv_filter(cf_b), .conv_ifmap(ci_b), .conv_psum(cp_b),
    .out_valid(ov_b), .out_data(od_b), .out_last(ol_b), .busy(busy_b), .done(done_b));

  // Datapath stand-ins: latch filter on state=1, dot product after L cycles.
  function automatic logic [15:0] dot(input logic [71:0] w, input logic [71:0] x);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 9; k++)
      s = s + 16'(w[71-8*k -: 8]) * 16'(x[71-8*k -: 8]);
    return s;
  endfunction

  logic [71:0] fa = '0, fb = '0;
  logic [15:0] pa = '0;
  logic [15:0] pb [3];
  initial for (int i = 0; i < 3; i++) pb[i] = '0;
  always @(posedge clk) begin
    if (cs_a) fa <= cf_a;
    if (cs_b) fb <= cf_b;
    pa    <= dot(fa, ci_a);
    pb[0] <= dot(fb, ci_b);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign cp_a = pa;
  assign cp_b = pb[2];

  // Expected psum for the window completed by accepting pixel (r,c);
  // pixel value equals its raster index.
  function automatic logic [15:0] win_sum(input logic [71:0] f, input int r, input int c);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s = s + 16'(f[71-8*(3*i+j) -: 8]) * 16'((r-2+i)*W + (c-2+j));
    return s;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst === 1'b0) begin
    if (ov_a) begin
      if (qa.size() == 0) check("A_unexpected_valid", 72'(ov_a), 72'(0));
      else begin
        ea = qa.pop_front();
        npop_a++;
        check("A_data", 72'(od_a), 72'(ea.data));
        check("A_last", 72'(ol_a), 72'(ea.last));
        check("A_cycle", 72'(cyc), 72'(ea.cyc));
      end
    end else if (ol_a) check("A_last_without_valid", 72'(ol_a), 72'(0));
    if (done_a) begin
      nd_a++;
      check("A_done_cycle", 72'(cyc), 72'(exp_done_a));
      check("A_ready_in_done", 72'(ready_a), 72'(0));
    end
  end

  always @(negedge clk) if (rst === 1'b0) begin
    if (ov_b) begin
      if (qb.size() == 0) check("B_unexpected_valid", 72'(ov_b), 72'(0));
      else begin
        eb = qb.pop_front();
        npop_b++;
        check("B_data", 72'(od_b), 72'(eb.data));
        check("B_last", 72'(ol_b), 72'(eb.last));
        check("B_cycle", 72'(cyc), 72'(eb.cyc));
      end
    end else if (ol_b) check("B_last_without_valid", 72'(ol_b), 72'(0));
    if (done_b) begin
      nd_b++;
      check("B_done_cycle", 72'(cyc), 72'(exp_done_b));
      check("B_ready_in_done", 72'(ready_b), 72'(0));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
    qa.delete();
    qb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("A_reset_ctrl", 72'({ready_a, cs_a, ov_a, ol_a, busy_a, done_a, od_a}), 72'(0));
    check("B_reset_ctrl", 72'({ready_b, cs_b, ov_b, ol_b, busy_b, done_b, od_b}), 72'(0));
    check("A_reset_filter", cf_a, 72'(0));
    check("B_reset_filter", cf_b, 72'(0));
    check("A_reset_ifmap", ci_a, 72'(0));
    check("B_reset_ifmap", ci_b, 72'(0));
    rst = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [71:0] f, input bit stall,
                           input bit mid_start, input int stop_at);
    int idx, budget, r, c, d0a, d0b, p0a, p0b;
    bit pulsed, fin;
    exp_t e;
    idx = 0; budget = 0; pulsed = 0; fin = 0;
    d0a = nd_a; d0b = nd_b; p0a = npop_a; p0b = npop_b;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_filter = f;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_filter = 72'hDEADBEEF0123456789;
    @(negedge clk);
    check({name, "_A_load_state"}, 72'(cs_a), 72'(1));
    check({name, "_B_load_state"}, 72'(cs_b), 72'(1));
    check({name, "_A_load_ifmap"}, ci_a, 72'(0));
    check({name, "_B_load_ifmap"}, ci_b, 72'(0));
    check({name, "_A_load_ready"}, 72'({ready_a, busy_a}), 72'(1));
    check({name, "_B_load_ready"}, 72'({ready_b, busy_b}), 72'(1));
    check({name, "_A_filter"}, cf_a, f);
    check({name, "_B_filter"}, cf_b, f);
    while (idx < W*H && idx != stop_at && budget < 200) begin
      @(posedge clk); #1;
      pix_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = 8'(idx);
      if (mid_start && idx == 5 && !pulsed) begin
        start = 1'b1;
        cfg_filter = 72'h020202020202020202;
        pulsed = 1;
      end else start = 1'b0;
      @(negedge clk);
      budget++;
      check({name, "_A_stream_ctrl"}, 72'({ready_a, cs_a, busy_a}), 72'(3'b101));
      check({name, "_B_stream_ctrl"}, 72'({ready_b, cs_b, busy_b}), 72'(3'b101));
      if (pix_valid && ready_a) begin
        r = idx / W;
        c = idx % W;
        if (r >= 2 && c >= 2) begin
          e.data = win_sum(f, r, c);
          e.last = (idx == W*H - 1);
          e.cyc  = cyc + 2;
          qa.push_back(e);
          e.cyc  = cyc + 4;
          qb.push_back(e);
          if (e.last) begin
            exp_done_a = cyc + 3;
            exp_done_b = cyc + 5;
          end
        end
        idx++;
      end
    end
    start = 1'b0;
    if (stop_at >= 0) begin
      check({name, "_stopped_at"}, 72'(idx), 72'(stop_at));
      return;
    end
    check({name, "_all_pixels_in"}, 72'(idx), 72'(W*H));
    for (int i = 0; i < 40 && !fin; i++) begin
      @(posedge clk); #1;
      pix_valid = 1'b0;
      @(negedge clk);
      check({name, "_A_ready_after_stream"}, 72'(ready_a), 72'(0));
      check({name, "_B_ready_after_stream"}, 72'(ready_b), 72'(0));
      if (nd_a > d0a && nd_b > d0b) fin = 1;
    end
    @(negedge clk);
    @(negedge clk);
    check({name, "_A_done_count"}, 72'(nd_a - d0a), 72'(1));
    check({name, "_B_done_count"}, 72'(nd_b - d0b), 72'(1));
    check({name, "_A_out_count"}, 72'(npop_a - p0a), 72'((W-2)*(H-2)));
    check({name, "_B_out_count"}, 72'(npop_b - p0b), 72'((W-2)*(H-2)));
    check({name, "_A_queue_left"}, 72'(qa.size()), 72'(0));
    check({name, "_B_queue_left"}, 72'(qb.size()), 72'(0));
    check({name, "_A_idle"}, 72'({busy_a, ready_a, cs_a}), 72'(0));
    check({name, "_B_idle"}, 72'({busy_b, ready_b, cs_b}), 72'(0));
    check({name, "_A_filter_held"}, cf_a, f);
    check({name, "_B_filter_held"}, cf_b, f);
  endtask

  initial begin
    int d_before;
    do_reset();
    run_frame("t1_centre", F1, 0, 0, -1);
    run_frame("t2_diag", F2, 0, 0, -1);
    run_frame("t3_stall", F1, 1, 0, -1);
    run_frame("t4_midstart", F1, 0, 1, -1);
    d_before = nd_a + nd_b;
    run_frame("t5_abort", F1, 0, 0, 7);
    do_reset();
    repeat (6) @(negedge clk);
    check("t5_no_done_after_abort", 72'(nd_a + nd_b), 72'(d_before));
    run_frame("t5_restart", F1, 0, 0, -1);
    run_frame("t6_stall_diag", F2, 1, 0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
